// File: rtl/x4_spi_reg_responder.sv
`timescale 1ns/1ps
// x4_spi_reg_responder: SPI mode-0 target for the X4 register path; 128x8 regfile also on a local port.
// Latency: wr_strobe/rd_strobe one clk after the synced 8th sclk rise; miso ~SYNC_STAGES+1 clk after sclk fall.
// Backpressure: none; SPI is master-paced (spi_sclk <= clk/8); local writes apply every cycle, SPI commit wins.
// Ports: clk/rst (async active-high); spi_sclk/spi_cs_n/spi_mosi in, spi_miso/spi_miso_oe out;
//        wr_strobe/rd_strobe/xfer_addr/xfer_data report committed bytes; local_addr/local_we/local_wdata/
//        local_rdata give direct regfile access; busy = frame open; frame_err = cs_n rose mid-byte.
module x4_spi_reg_responder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  RESET_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       wr_strobe,
    output logic       rd_strobe,
    output logic [6:0] xfer_addr,
    output logic [7:0] xfer_data,
    input  logic [6:0] local_addr,
    input  logic       local_we,
    input  logic [7:0] local_wdata,
    output logic [7:0] local_rdata,
    output logic       busy,
    output logic       frame_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_WDATA, ST_RDATA} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             rx_shift_q, rx_shift_d;
    logic [6:0]             addr_q, addr_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   wr_strobe_q, wr_strobe_d;
    logic                   rd_strobe_q, rd_strobe_d;
    logic [6:0]             xfer_addr_q, xfer_addr_d;
    logic [7:0]             xfer_data_q, xfer_data_d;
    logic                   busy_q, busy_d;
    logic                   frame_err_q, frame_err_d;

    logic [7:0] regfile [128];
    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [7:0] rx_byte;
    logic       spi_we;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    // Complete byte as it stands on the current rise: 7 stored bits plus the bit being sampled now.
    assign rx_byte   = {rx_shift_q, mosi_s};

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        addr_d      = addr_q;
        tx_shift_d  = tx_shift_q;
        tx_byte_d   = tx_byte_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        wr_strobe_d = 1'b0;
        rd_strobe_d = 1'b0;
        xfer_addr_d = xfer_addr_q;
        xfer_data_d = xfer_data_q;
        busy_d      = busy_q;
        frame_err_d = 1'b0;
        spi_we      = 1'b0;

        if (state_q != ST_IDLE && cs_rise) begin
            // Any partial byte is dropped; only a non-zero bit count is an error.
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            miso_oe_d   = 1'b0;
            miso_d      = 1'b0;
            frame_err_d = (bit_cnt_q != 3'd0);
            bit_cnt_d   = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_ADDR;
                        bit_cnt_d = 3'd0;
                        busy_d    = 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        rx_shift_d = rx_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = rx_byte[6:0];
                            if (rx_byte[7]) begin
                                tx_shift_d = regfile[rx_byte[6:0]];
                                tx_byte_d  = regfile[rx_byte[6:0]];
                                miso_oe_d  = 1'b1;
                                miso_d     = 1'b0;
                                state_d    = ST_RDATA;
                            end else begin
                                state_d    = ST_WDATA;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        rx_shift_d = rx_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            spi_we      = 1'b1;
                            wr_strobe_d = 1'b1;
                            xfer_addr_d = addr_q;
                            xfer_data_d = rx_byte;
                            addr_d      = addr_q + 7'd1;
                        end
                    end
                end
                ST_RDATA: begin
                    // Present on the fall so the bit is settled before the master's next rise.
                    if (sclk_fall) begin
                        miso_d     = tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rd_strobe_d = 1'b1;
                            xfer_addr_d = addr_q;
                            xfer_data_d = tx_byte_q;
                            addr_d      = addr_q + 7'd1;
                            tx_shift_d  = regfile[addr_q + 7'd1];
                            tx_byte_d   = regfile[addr_q + 7'd1];
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 7'd0;
            addr_q      <= 7'd0;
            tx_shift_q  <= 8'd0;
            tx_byte_q   <= 8'd0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            xfer_addr_q <= 7'd0;
            xfer_data_q <= 8'd0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            addr_q      <= addr_d;
            tx_shift_q  <= tx_shift_d;
            tx_byte_q   <= tx_byte_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            wr_strobe_q <= wr_strobe_d;
            rd_strobe_q <= rd_strobe_d;
            xfer_addr_q <= xfer_addr_d;
            xfer_data_q <= xfer_data_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Register file: one flop byte per entry; an SPI commit overrides a same-cycle local write
    // to the same entry, writes to different entries both land.
    for (genvar g = 0; g < 128; g++) begin : g_reg
        logic [7:0] ent_q, ent_d;
        always_comb begin
            ent_d = ent_q;
            if (local_we && local_addr == 7'(g)) ent_d = local_wdata;
            if (spi_we && addr_q == 7'(g))       ent_d = rx_byte;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) ent_q <= RESET_VALUE;
            else     ent_q <= ent_d;
        end
        assign regfile[g] = ent_q;
    end

    assign spi_miso    = miso_q & miso_oe_q;
    assign spi_miso_oe = miso_oe_q;
    assign wr_strobe   = wr_strobe_q;
    assign rd_strobe   = rd_strobe_q;
    assign xfer_addr   = xfer_addr_q;
    assign xfer_data   = xfer_data_q;
    assign busy        = busy_q;
    assign frame_err   = frame_err_q;
    assign local_rdata = regfile[local_addr];

endmodule

// File: tb/tb_x4_spi_reg_responder.sv
`timescale 1ns/1ps
module tb_x4_spi_reg_responder;

    localparam logic [7:0] RV = 8'h5A;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sclk, spi_cs_n, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic       wr_strobe, rd_strobe;
    logic [6:0] xfer_addr;
    logic [7:0] xfer_data;
    logic [6:0] local_addr;
    logic       local_we;
    logic [7:0] local_wdata, local_rdata;
    logic       busy, frame_err;

    always #5 clk = ~clk;

    x4_spi_reg_responder #(.SYNC_STAGES(2), .RESET_VALUE(RV)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .wr_strobe(wr_strobe), .rd_strobe(rd_strobe),
        .xfer_addr(xfer_addr), .xfer_data(xfer_data),
        .local_addr(local_addr), .local_we(local_we),
        .local_wdata(local_wdata), .local_rdata(local_rdata),
        .busy(busy), .frame_err(frame_err)
    );

    typedef struct {
        logic       rd;
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [7:0] mdl [128];
    int         checks = 0;
    int         failures = 0;
    int         ferr_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Strobe monitor: every strobe cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (wr_strobe === 1'b1 || rd_strobe === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", {30'd0, wr_strobe, rd_strobe}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("strobe_kind", {30'd0, wr_strobe, rd_strobe}, mon_e.rd ? 32'd1 : 32'd2);
                chk("strobe_addr", {25'd0, xfer_addr}, {25'd0, mon_e.addr});
                chk("strobe_data", {24'd0, xfer_data}, {24'd0, mon_e.data});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Shift nbits of tx (MSB first); sample miso/oe at each rising sclk. Optional local
    // write pulse lands on the same clk as the DUT commit of the last bit.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit lw,
                            output logic [7:0] rx, output logic oe_any, output logic oe_all);
        rx = 8'd0; oe_any = 1'b0; oe_all = 1'b1;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = tx[i];
            repeat (4) @(negedge clk);
            spi_sclk = 1'b1;
            rx[i]  = spi_miso;
            oe_any = oe_any | spi_miso_oe;
            oe_all = oe_all & spi_miso_oe;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (lw && i == 0) local_we = (k == 1);
            end
            spi_sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic frame_begin();
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (8) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic addr_byte(input logic [7:0] b, input string tag);
        logic [7:0] rx; logic any, all;
        spi_xfer(b, 8, 1'b0, rx, any, all);
        chk({tag, "_addr_oe"}, {31'd0, any}, 32'd0);
    endtask

    task automatic wr_byte(input logic [6:0] a, input logic [7:0] d, input bit lw);
        logic [7:0] rx; logic any, all;
        sb_q.push_back('{rd: 1'b0, addr: a, data: d});
        mdl[a] = d;
        spi_xfer(d, 8, lw, rx, any, all);
    endtask

    task automatic rd_byte(input logic [6:0] a, input string tag);
        logic [7:0] rx; logic any, all;
        sb_q.push_back('{rd: 1'b1, addr: a, data: mdl[a]});
        spi_xfer(8'h00, 8, 1'b0, rx, any, all);
        chk({tag, "_miso"}, {24'd0, rx}, {24'd0, mdl[a]});
        chk({tag, "_oe"}, {31'd0, all}, 32'd1);
    endtask

    task automatic peek(input logic [6:0] a, input string tag);
        local_addr = a;
        #1;
        chk(tag, {24'd0, local_rdata}, {24'd0, mdl[a]});
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_miso"}, {31'd0, spi_miso}, 32'd0);
        chk({tag, "_oe"},   {31'd0, spi_miso_oe}, 32'd0);
        chk({tag, "_wr"},   {31'd0, wr_strobe}, 32'd0);
        chk({tag, "_rd"},   {31'd0, rd_strobe}, 32'd0);
        chk({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_xaddr"}, {25'd0, xfer_addr}, 32'd0);
        chk({tag, "_xdata"}, {24'd0, xfer_data}, 32'd0);
    endtask

    initial begin
        logic [7:0] rx; logic any, all;
        rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        local_addr = 7'd0; local_we = 1'b0; local_wdata = 8'd0;
        for (int i = 0; i < 128; i++) mdl[i] = RV;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        peek(7'h12, "reset_rf12");
        peek(7'h7F, "reset_rf7f");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single write
        frame_begin();
        chk("w1_busy", {31'd0, busy}, 32'd1);
        addr_byte(8'h12, "w1");
        wr_byte(7'h12, 8'hA5, 1'b0);
        frame_end();
        chk("w1_busy_end", {31'd0, busy}, 32'd0);
        peek(7'h12, "w1_rf12");

        // Single read
        frame_begin();
        addr_byte(8'h92, "r1");
        rd_byte(7'h12, "r1");
        frame_end();
        chk("r1_oe_end", {31'd0, spi_miso_oe}, 32'd0);
        chk("r1_miso_end", {31'd0, spi_miso}, 32'd0);

        // Burst write and read across the 7F->00 wrap
        frame_begin();
        addr_byte(8'h7F, "bw");
        wr_byte(7'h7F, 8'h11, 1'b0);
        wr_byte(7'h00, 8'h22, 1'b0);
        frame_end();
        peek(7'h7F, "bw_rf7f");
        peek(7'h00, "bw_rf00");
        frame_begin();
        addr_byte(8'hFF, "br");
        rd_byte(7'h7F, "br0");
        rd_byte(7'h00, "br1");
        frame_end();

        // Abort after 5 data bits, then a clean address-only frame
        frame_begin();
        addr_byte(8'h20, "ab");
        spi_xfer(8'hC7, 5, 1'b0, rx, any, all);
        frame_end();
        chk("ab_ferr", ferr_cnt, 32'd1);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        peek(7'h20, "ab_rf20");
        frame_begin();
        addr_byte(8'h40, "clean");
        frame_end();
        chk("clean_ferr", ferr_cnt, 32'd1);

        // Same-address collision (SPI wins), then different-address same-cycle writes
        local_addr = 7'h30; local_wdata = 8'h55;
        frame_begin();
        addr_byte(8'h30, "col");
        wr_byte(7'h30, 8'hAA, 1'b1);
        frame_end();
        peek(7'h30, "col_rf30");
        local_addr = 7'h31; local_wdata = 8'h66; mdl[7'h31] = 8'h66;
        frame_begin();
        addr_byte(8'h32, "dif");
        wr_byte(7'h32, 8'h77, 1'b1);
        frame_end();
        peek(7'h31, "dif_rf31");
        peek(7'h32, "dif_rf32");
        frame_begin();
        addr_byte(8'hB1, "lr");
        rd_byte(7'h31, "lr");
        frame_end();

        // Reset during bit 3 of a read data byte
        frame_begin();
        addr_byte(8'h92, "rr");
        spi_xfer(8'h00, 3, 1'b0, rx, any, all);
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        spi_sclk = 1'b1;
        repeat (2) @(negedge clk);
        chk("rr_pre_oe", {31'd0, spi_miso_oe}, 32'd1);
        rst = 1'b1;
        #1;
        chk_outputs_zero("rr");
        spi_sclk = 1'b0; spi_cs_n = 1'b1;
        for (int i = 0; i < 128; i++) mdl[i] = RV;
        repeat (5) @(negedge clk);
        peek(7'h12, "rr_rf12");
        peek(7'h30, "rr_rf30");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        frame_begin();
        addr_byte(8'h05, "pw");
        wr_byte(7'h05, 8'hC3, 1'b0);
        frame_end();
        frame_begin();
        addr_byte(8'h85, "pr");
        rd_byte(7'h05, "pr0");
        rd_byte(7'h06, "pr1");
        frame_end();

        repeat (20) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        chk("final_ferr", ferr_cnt, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
